// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst transmitter: FSM encoding and word width.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  // One status bit (FIFO empty) is prepended to every payload word.
  function automatic int word_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser plus an edge-detect flop; emits one-clk rise/fall pulses.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Metastability chain followed by the delayed copy used for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_burst_tx.sv
// SPI slave transmitter streaming FIFO words back-to-back as {empty, data}.
// mclk and cs are oversampled on clk; all state lives in the clk domain.
module spi_burst_tx
  import spi_pkg::*;
#(
  parameter int DATA_W = 15,
  parameter int CPOL   = 0,
  parameter int CPHA   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mclk,
  input  logic              cs,
  output logic              miso,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              busy,
  output logic              underrun,
  output logic [CNT_W-1:0]  frame_words
);

  localparam int WORD_W = word_w(DATA_W);
  localparam int BC_W   = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

  spi_state_e r_state;
  spi_state_e w_nxt;

  logic w_mclk_rise, w_mclk_fall;
  logic w_cs_rise, w_cs_fall;
  logic w_lead, w_trail, w_samp, w_shift;
  logic w_in_shift, w_word_done, w_cap;

  logic [1:0]        r_warm;
  logic              r_cs_ok;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WORD_W-1:0] r_shreg;
  logic              r_miso;
  logic              r_busy;
  logic              r_fifo_rd;
  logic              r_underrun;
  logic [CNT_W-1:0]  r_frame_words;
  logic [DATA_W-1:0] w_data;
  logic [WORD_W-1:0] w_word;

  spi_sync #(.RST_VAL(1'b0)) u_mclk_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_async (mclk),
    .o_rise  (w_mclk_rise),
    .o_fall  (w_mclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_async (cs),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  assign w_lead  = (CPOL == 0) ? w_mclk_rise : w_mclk_fall;
  assign w_trail = (CPOL == 0) ? w_mclk_fall : w_mclk_rise;
  assign w_samp  = (CPHA == 0) ? w_lead  : w_trail;
  assign w_shift = (CPHA == 0) ? w_trail : w_lead;

  // The cs chain resets high, so a cs held low through reset produces a fake
  // fall once the chain fills. Only trust cs after it has genuinely been high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm  <= 2'd0;
      r_cs_ok <= 1'b0;
    end else begin
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
      if (w_cs_rise || (r_warm == 2'd2 && !w_cs_fall)) r_cs_ok <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // Next state: cs fall arms a frame, cs rise ends it from anywhere.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cs_fall && r_cs_ok) w_nxt = ST_ARM;
      ST_ARM:   w_nxt = ST_SHIFT;
      ST_SHIFT: w_nxt = ST_SHIFT;
      default:  w_nxt = ST_IDLE;
    endcase
    if (w_cs_rise) w_nxt = ST_IDLE;
  end

  assign w_in_shift  = (r_state == ST_SHIFT);
  assign w_word_done = w_in_shift && w_samp && (r_bit_cnt == BC_LAST);
  // A word captured as cs rises could never be sent, so it is not popped.
  assign w_cap       = !w_cs_rise && ((r_state == ST_ARM) || w_word_done);
  assign w_cnt_nxt   = (w_word_done && (r_word_cnt != '1)) ? r_word_cnt + 1'b1 : r_word_cnt;
  assign w_data      = fifo_empty ? {DATA_W{1'b0}} : fifo_data;
  assign w_word      = {fifo_empty, w_data};

  // Bit and word counters run only inside SHIFT and restart every frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (w_in_shift) begin
      if (w_samp) r_bit_cnt <= (r_bit_cnt == BC_LAST) ? '0 : r_bit_cnt + 1'b1;
      r_word_cnt <= w_cnt_nxt;
    end else begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end
  end

  // Status outputs: pop/underrun strobes follow capture, frame length on cs rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy        <= 1'b0;
      r_fifo_rd     <= 1'b0;
      r_underrun    <= 1'b0;
      r_frame_words <= '0;
    end else begin
      r_busy     <= (w_nxt != ST_IDLE);
      r_fifo_rd  <= w_cap & ~fifo_empty;
      r_underrun <= w_cap & fifo_empty;
      if (w_cs_rise && (r_state != ST_IDLE)) r_frame_words <= w_cnt_nxt;
    end
  end

  // Shift path. CPHA=0 drives the MSB at capture and shifts on trailing edges,
  // skipping the trailing edge that closes a word since the next word is
  // already on the line. CPHA=1 loads silently and shifts on leading edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_miso  <= 1'b0;
    end else if ((r_state == ST_IDLE) || w_cs_rise) begin
      r_shreg <= '0;
      r_miso  <= 1'b0;
    end else if (w_cap) begin
      if (CPHA == 0) begin
        r_miso  <= w_word[WORD_W-1];
        r_shreg <= {w_word[WORD_W-2:0], 1'b0};
      end else begin
        r_shreg <= w_word;
      end
    end else if (w_in_shift && w_shift && ((CPHA != 0) || (r_bit_cnt != '0))) begin
      r_miso  <= r_shreg[WORD_W-1];
      r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
    end
  end

  assign miso        = r_miso;
  assign busy        = r_busy;
  assign fifo_rd     = r_fifo_rd;
  assign underrun    = r_underrun;
  assign frame_words = r_frame_words;

endmodule

// File: tb/tb_spi_burst_tx.sv
// Bench for spi_burst_tx: one instance per CPOL/CPHA mode, a behavioural SPI
// master, a FWFT FIFO model and a word scoreboard.
module tb_spi_burst_tx;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  logic mclk_bus;
  logic cs_bus;
  logic mon_en;
  int   act;

  logic        fe_v;
  logic [14:0] fd_v;
  logic [14:0] fq[$];
  logic [15:0] exp_q[$];

  logic [3:0]  mclk_w, cs_w, fe_w, miso_w, fifo_rd_w, busy_w, underrun_w;
  logic [15:0] fw_w [4];

  int n_chk  = 0;
  int n_pass = 0;
  int pop_cnt = 0;
  int und_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign mclk_w[g] = (act == g) ? mclk_bus : (g >= 2);
    assign cs_w[g]   = (act == g) ? cs_bus : 1'b1;
    assign fe_w[g]   = (act == g) ? fe_v : 1'b1;
    spi_burst_tx #(.DATA_W(15), .CPOL(g / 2), .CPHA(g % 2), .CNT_W(16)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mclk        (mclk_w[g]),
      .cs          (cs_w[g]),
      .miso        (miso_w[g]),
      .fifo_empty  (fe_w[g]),
      .fifo_data   (fd_v),
      .fifo_rd     (fifo_rd_w[g]),
      .busy        (busy_w[g]),
      .underrun    (underrun_w[g]),
      .frame_words (fw_w[g])
    );
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (mode %0d, t=%0t)", nm, got, exp, act, $time);
  endtask

  // FWFT FIFO: pops on the strobe, head/empty refreshed away from posedge.
  // Data shown while empty is junk so the zeroing of the data field is visible.
  initial forever begin
    @(negedge clk);
    if (fifo_rd_w[act]) begin
      pop_cnt++;
      if (fq.size() > 0) void'(fq.pop_front());
      else chk("pop while empty", 1, 0);
    end
    if (underrun_w[act]) und_cnt++;
    fe_v = (fq.size() == 0);
    fd_v = fe_v ? 15'h2A5A : fq[0];
  end

  // Monitor: acts as the master's receiver, sampling miso on the mode's
  // sample edge and checking each completed word against the scoreboard.
  initial begin
    logic pm, pc;
    logic [15:0] sh;
    int nb;
    pm = 1'b0; pc = 1'b1; sh = '0; nb = 0;
    forever begin
      @(mclk_bus or cs_bus);
      if (mclk_bus != pm && !pc && mon_en && (mclk_bus == ((act / 2) == (act % 2)))) begin
        sh = {sh[14:0], miso_w[act]};
        nb++;
        if (nb == W) begin
          nb = 0;
          if (exp_q.size() == 0) chk("unexpected word", sh, 17'h10000);
          else chk("word", sh, exp_q.pop_front());
        end
      end
      if (cs_bus != pc) nb = 0;
      pm = mclk_bus;
      pc = cs_bus;
    end
  end

  task automatic set_mode(input int m);
    act = m;
    mclk_bus = (m >= 2);
    repeat (4) @(negedge clk);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) fq.push_back(15'($urandom));
  endtask

  // One mclk period; half periods are 4 clk, or 3..5 clk with jitter.
  task automatic mclk_cycle(input bit jit, input bit raise_cs);
    int h1, h2;
    h1 = jit ? int'($urandom_range(3, 5)) : 4;
    h2 = jit ? int'($urandom_range(3, 5)) : 4;
    mclk_bus = (act < 2);
    repeat (h1) @(negedge clk);
    mclk_bus = (act >= 2);
    if (raise_cs) cs_bus = 1'b1;
    repeat (h2) @(negedge clk);
  endtask

  task automatic run_frame(input int nbits, input bit jit, input int inj_bit, input logic [14:0] inj);
    cs_bus = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy in frame", busy_w[act], 1);
    for (int i = 0; i < nbits; i++) begin
      if (i == inj_bit) fq.push_back(inj);
      mclk_cycle(jit, i == nbits - 1);
    end
    repeat (10) @(negedge clk);
  endtask

  // Reference: one capture at frame start plus one per completed word, except
  // a capture that coincides with cs rising (CPHA=1, word-aligned end).
  task automatic do_frame(input int nbits, input bit jit);
    int k, caps, npop, p0, u0;
    k = fq.size();
    caps = 1 + nbits / W;
    if ((act % 2 == 1) && (nbits % W == 0)) caps--;
    npop = (caps < k) ? caps : k;
    for (int i = 0; i < nbits / W; i++)
      exp_q.push_back((i < k) ? {1'b0, fq[i]} : 16'h8000);
    p0 = pop_cnt;
    u0 = und_cnt;
    run_frame(nbits, jit, -1, 15'h0);
    chk("fifo_rd count", pop_cnt - p0, npop);
    chk("underrun count", und_cnt - u0, caps - npop);
    chk("frame_words", fw_w[act], nbits / W);
    chk("busy after frame", busy_w[act], 0);
    chk("fifo level", fq.size(), k - npop);
  endtask

  initial begin
    logic [14:0] w3, d;
    int p0, u0;
    act = 1; mclk_bus = 1'b0; cs_bus = 1'b1; rst_n = 1'b0; mon_en = 1'b1;
    fe_v = 1'b1; fd_v = '0;
    repeat (5) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("reset busy", busy_w[g], 0);
      chk("reset miso", miso_w[g], 0);
      chk("reset fifo_rd", fifo_rd_w[g], 0);
      chk("reset underrun", underrun_w[g], 0);
      chk("reset frame_words", fw_w[g], 0);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Basic burst then the same data in every mode.
    for (int m = 1; m < 5; m++) begin
      set_mode(m % 4);
      fq.delete();
      fq.push_back(15'h1234);
      fq.push_back(15'h0ABC);
      do_frame(48, 1'b0);
    end

    // Abort after 7 bits of word 2; the next frame resumes at the third word.
    set_mode(1);
    fq.delete();
    fill(5);
    w3 = fq[2];
    do_frame(23, 1'b0);
    chk("fifo head after abort", fq[0], w3);
    do_frame(32, 1'b0);

    // Empty at cs fall, data arrives during bit 5.
    fq.delete();
    d = 15'($urandom);
    exp_q.push_back(16'h8000);
    exp_q.push_back({1'b0, d});
    p0 = pop_cnt; u0 = und_cnt;
    run_frame(32, 1'b0, 5, d);
    chk("late data fifo_rd", pop_cnt - p0, 1);
    chk("late data underrun", und_cnt - u0, 1);
    chk("late data frame_words", fw_w[act], 2);

    // Reset mid-frame while cs stays low.
    fq.delete();
    fill(3);
    mon_en = 1'b0;
    cs_bus = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) mclk_cycle(1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("post-reset miso", miso_w[act], 0);
    chk("post-reset busy", busy_w[act], 0);
    p0 = pop_cnt;
    for (int i = 0; i < 20; i++) mclk_cycle(1'b0, 1'b0);
    chk("cs-low after reset busy", busy_w[act], 0);
    chk("cs-low after reset miso", miso_w[act], 0);
    chk("cs-low after reset fifo_rd", pop_cnt - p0, 0);
    chk("cs-low after reset frame_words", fw_w[act], 0);
    cs_bus = 1'b1;
    repeat (8) @(negedge clk);
    mon_en = 1'b1;
    do_frame(32, 1'b0);

    // Random frames in random modes with jittered mclk.
    for (int f = 0; f < 12; f++) begin
      set_mode(int'($urandom_range(0, 3)));
      fill(int'($urandom_range(0, 5)));
      do_frame(int'($urandom_range(17, 80)), 1'b1);
    end

    // Long jittered bursts.
    for (int f = 0; f < 8; f++) begin
      set_mode(f % 4);
      fill(int'($urandom_range(20, 31)));
      do_frame(30 * W, 1'b1);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
